shift_frame_ctrl: RTL

Serial-to-parallel frame controller. It sequences an internal `shift_left_register` #(BITS) to collect a frame of BITS serial bits, then copies the frame into an output holding register. The frame is presented on a valid/ready handshake. It sits between a bit-serial source (sampled input, keyboard/PS2-style or SPI-style line) and parallel consumers in the display pipeline. Clearing, enabling and feeding the shift register are owned entirely by this FSM.

---
 rtl/shift_frame_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/shift_frame_ctrl.sv
// Serial-to-parallel frame controller: collects BITS serial bits through an
// internal left-shift register and hands each frame out on a valid/ready port.

module shift_left_register #(
  parameter int BITS = 5
) (
  input  logic            clk,
  input  logic            i_sclr,
  input  logic            i_en,
  input  logic            i_dat,
  output logic [BITS-1:0] o_q
);

  logic [BITS-1:0] q_q;

  // New bits enter at the LSB, so the earliest bit ends up at the MSB.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      q_q <= '0;
    end else if (i_en) begin
      q_q <= {q_q[BITS-2:0], i_dat};
    end
  end

  assign o_q = q_q;

endmodule

module shift_frame_ctrl #(
  parameter int BITS = 5
) (
  input  logic            clk,
  input  logic            i_sclr,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_bit_valid,
  input  logic            i_bit,
  input  logic            i_ready,
  output logic [BITS-1:0] o_data,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_overrun
);

  localparam int CNT_W = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  logic            abort_act;
  logic            start_acc;
  logic            sr_sclr;
  logic            sr_en;
  logic [BITS-1:0] sr_q;

  shift_left_register #(.BITS(BITS)) u_sr (
    .clk    (clk),
    .i_sclr (sr_sclr),
    .i_en   (sr_en),
    .i_dat  (i_bit),
    .o_q    (sr_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // Abort only matters mid-frame; a start during LOAD is dropped so the load completes.
    abort_act = i_abort & (state_q != IDLE);
    start_acc = i_start & ~abort_act & (state_q != LOAD);
    sr_sclr   = i_sclr | start_acc | abort_act;
    sr_en     = (state_q == SHIFT) & i_bit_valid & ~i_abort & ~i_start;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (abort_act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (start_acc) begin
          cnt_d = '0;
        end else if (sr_en) begin
          if (cnt_q == CNT_W'(BITS - 1)) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
        // A consumer taking the old frame this cycle frees the slot for the new one.
        if (!abort_act) begin
          if (!valid_q || i_ready) begin
            data_d  = sr_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = (state_q != IDLE);
  assign o_overrun = overrun_q;

endmodule
